// File: rtl/store_buffer.sv
// In-order store buffer: queues committed stores, drains them as lane-aligned
// word writes with byte strobes, and flags loads that hit a buffered word.
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             st_valid,
    output logic             st_ready,
    input  logic [31:0]      st_addr,
    input  logic [31:0]      st_data,
    input  logic [1:0]       st_size,
    output logic             st_err,
    input  logic             flush,
    output logic             mem_wvalid,
    input  logic             mem_wready,
    output logic [31:0]      mem_waddr,
    output logic [31:0]      mem_wdata,
    output logic [3:0]       mem_wstrb,
    input  logic             ld_check,
    input  logic [31:0]      ld_addr,
    output logic             ld_hazard,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output logic             full
);

    localparam int PTR_W = $clog2(DEPTH);

    function automatic logic is_legal(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'd0:    is_legal = 1'b1;
            2'd1:    is_legal = (off[0] == 1'b0);
            2'd2:    is_legal = (off == 2'b00);
            default: is_legal = 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] lane_strb(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'd0:    lane_strb = 4'b0001 << off;
            2'd1:    lane_strb = 4'b0011 << off;
            default: lane_strb = 4'b1111;
        endcase
    endfunction

    logic [29:0]      addr_r [DEPTH];
    logic [31:0]      data_r [DEPTH];
    logic [3:0]       strb_r [DEPTH];
    logic [PTR_W-1:0] head_r;
    logic [PTR_W-1:0] tail_r;
    logic [CNT_W-1:0] count_r;
    logic             err_r;

    logic             empty_s;
    logic             full_s;
    logic             ready_s;
    logic             acc_s;
    logic             legal_s;
    logic             enq_s;
    logic             deq_s;
    logic             hit_s;
    logic [PTR_W-1:0] rel_s;
    logic [1:0]       unused_ld_lsb_s;

    assign empty_s         = (count_r == {CNT_W{1'b0}});
    assign full_s          = (count_r == CNT_W'(DEPTH));
    assign ready_s         = !full_s && !flush;
    assign acc_s           = st_valid && ready_s;
    assign legal_s         = is_legal(st_size, st_addr[1:0]);
    assign enq_s           = acc_s && legal_s;
    assign deq_s           = !empty_s && mem_wready;
    assign unused_ld_lsb_s = ld_addr[1:0];

    // Pointer, occupancy and error-pulse state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_r  <= {PTR_W{1'b0}};
            tail_r  <= {PTR_W{1'b0}};
            count_r <= {CNT_W{1'b0}};
            err_r   <= 1'b0;
        end else begin
            if (enq_s) tail_r <= tail_r + PTR_W'(1);
            if (deq_s) head_r <= head_r + PTR_W'(1);
            case ({enq_s, deq_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
            err_r <= acc_s && !legal_s;
        end
    end

    // Entry payload is encoded to lane alignment at enqueue; no reset needed.
    always_ff @(posedge clk) begin
        if (enq_s) begin
            addr_r[tail_r] <= st_addr[31:2];
            data_r[tail_r] <= st_data << {st_addr[1:0], 3'b000};
            strb_r[tail_r] <= lane_strb(st_size, st_addr[1:0]);
        end
    end

    // An entry is live when its distance from head is below the occupancy.
    always_comb begin
        hit_s = 1'b0;
        rel_s = {PTR_W{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            rel_s = PTR_W'(i) - head_r;
            if ((CNT_W'(rel_s) < count_r) && (addr_r[i] == ld_addr[31:2])) begin
                hit_s = 1'b1;
            end else begin
                hit_s = hit_s;
            end
        end
    end

    assign st_ready   = ready_s;
    assign st_err     = err_r;
    assign mem_wvalid = !empty_s;
    assign mem_waddr  = {addr_r[head_r], 2'b00};
    assign mem_wdata  = data_r[head_r];
    assign mem_wstrb  = strb_r[head_r];
    assign ld_hazard  = ld_check && hit_s;
    assign count      = count_r;
    assign empty      = empty_s;
    assign full       = full_s;

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: directed vector table, hand sequences
// for multi-cycle corners, and random traffic against a queue-based model.
module tb_store_buffer;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rst;
    logic        st_valid;
    logic        st_ready;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic [1:0]  st_size;
    logic        st_err;
    logic        flush;
    logic        mem_wvalid;
    logic        mem_wready;
    logic [31:0] mem_waddr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        ld_check;
    logic [31:0] ld_addr;
    logic        ld_hazard;
    logic [2:0]  count;
    logic        empty;
    logic        full;

    store_buffer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr),
        .st_data(st_data), .st_size(st_size), .st_err(st_err), .flush(flush),
        .mem_wvalid(mem_wvalid), .mem_wready(mem_wready), .mem_waddr(mem_waddr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .ld_check(ld_check), .ld_addr(ld_addr), .ld_hazard(ld_hazard),
        .count(count), .empty(empty), .full(full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] waddr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } ent_t;

    typedef struct {
        logic        sv;
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  size;
        logic        wr;
        logic        lc;
        logic [31:0] la;
        logic [2:0]  e_cnt;
        logic        e_rdy;
        logic        e_wv;
        logic [31:0] e_waddr;
        logic [3:0]  e_wstrb;
        logic [31:0] e_wdata;
        logic        e_err;
        logic        e_haz;
    } vec_t;

    ent_t model_q[$];
    logic err_exp;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic legal(input logic [31:0] a, input logic [1:0] sz);
        if (sz == 2'd3) return 1'b0;
        return (a % (32'd1 << sz)) == 32'd0;
    endfunction

    // Places each source byte into its memory lane, one byte at a time.
    function automatic ent_t encode(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
        ent_t e;
        int nb;
        int off;
        nb = 1 << sz;
        off = int'(a % 32'd4);
        e.waddr = a - 32'(off);
        e.wdata = 32'h0;
        e.wstrb = 4'h0;
        for (int b = 0; b < nb; b++) begin
            e.wstrb[off + b] = 1'b1;
            e.wdata[(off + b) * 8 +: 8] = d[b * 8 +: 8];
        end
        return e;
    endfunction

    function automatic logic [31:0] lane_mask(input logic [3:0] s);
        logic [31:0] m;
        m = 32'h0;
        for (int l = 0; l < 4; l++) if (s[l]) m[l * 8 +: 8] = 8'hFF;
        return m;
    endfunction

    // Drive one cycle of inputs and compare every output against the model.
    task automatic apply(input logic sv, input logic [31:0] a, input logic [31:0] d,
                         input logic [1:0] sz, input logic fl, input logic wr,
                         input logic lc, input logic [31:0] la);
        logic exp_haz;
        logic [31:0] m;
        st_valid = sv; st_addr = a; st_data = d; st_size = sz;
        flush = fl; mem_wready = wr; ld_check = lc; ld_addr = la;
        #1;
        chk("st_ready", 32'(st_ready), 32'((model_q.size() < DEPTH) && !fl));
        chk("count", 32'(count), 32'(model_q.size()));
        chk("empty", 32'(empty), 32'(model_q.size() == 0));
        chk("full", 32'(full), 32'(model_q.size() == DEPTH));
        chk("mem_wvalid", 32'(mem_wvalid), 32'(model_q.size() != 0));
        chk("st_err", 32'(st_err), 32'(err_exp));
        exp_haz = 1'b0;
        foreach (model_q[i]) if (model_q[i].waddr[31:2] == la[31:2]) exp_haz = 1'b1;
        chk("ld_hazard", 32'(ld_hazard), 32'(exp_haz && lc));
        if (model_q.size() != 0) begin
            m = lane_mask(model_q[0].wstrb);
            chk("mem_waddr", mem_waddr, model_q[0].waddr);
            chk("mem_wstrb", 32'(mem_wstrb), 32'(model_q[0].wstrb));
            chk("mem_wdata", mem_wdata & m, model_q[0].wdata & m);
        end
    endtask

    // Clock edge: retire head, then enqueue the accepted store if legal.
    task automatic step();
        logic acc;
        acc = st_valid && (model_q.size() < DEPTH) && !flush;
        @(posedge clk);
        if (mem_wready && model_q.size() != 0) void'(model_q.pop_front());
        if (acc && legal(st_addr, st_size)) model_q.push_back(encode(st_addr, st_data, st_size));
        err_exp = acc && !legal(st_addr, st_size);
        #1;
    endtask

    task automatic idle(input logic wr);
        apply(1'b0, 32'h0, 32'h0, 2'd0, 1'b0, wr, 1'b0, 32'h0);
        step();
    endtask

    task automatic do_reset();
        st_valid = 1'b0; st_addr = 32'h0; st_data = 32'h0; st_size = 2'd0;
        flush = 1'b0; mem_wready = 1'b0; ld_check = 1'b0; ld_addr = 32'h0;
        rst = 1'b0;
        model_q.delete();
        err_exp = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_wvalid", 32'(mem_wvalid), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_err", 32'(st_err), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic sv, input logic [31:0] addr, input logic [31:0] data,
                                input logic [1:0] size, input logic wr, input logic lc,
                                input logic [31:0] la, input logic [2:0] e_cnt, input logic e_rdy,
                                input logic e_wv, input logic [31:0] e_waddr, input logic [3:0] e_wstrb,
                                input logic [31:0] e_wdata, input logic e_err, input logic e_haz);
        vec_t v;
        v.sv = sv; v.addr = addr; v.data = data; v.size = size; v.wr = wr; v.lc = lc; v.la = la;
        v.e_cnt = e_cnt; v.e_rdy = e_rdy; v.e_wv = e_wv; v.e_waddr = e_waddr;
        v.e_wstrb = e_wstrb; v.e_wdata = e_wdata; v.e_err = e_err; v.e_haz = e_haz;
        return v;
    endfunction

    vec_t tbl[$];

    initial begin
        vec_t v;
        logic [31:0] ra;
        logic [31:0] rla;

        // Byte store, fill to full, drain, illegal stores, load hazard.
        tbl.push_back(mk(1, 32'h80000003, 32'h000000AB, 0, 1, 0, 0, 0, 1, 0, 32'h0, 4'h0, 32'h0, 0, 0));
        tbl.push_back(mk(0, 32'h0, 32'h0, 0, 1, 0, 0, 1, 1, 1, 32'h80000000, 4'b1000, 32'hAB000000, 0, 0));
        tbl.push_back(mk(0, 32'h0, 32'h0, 0, 0, 0, 0, 0, 1, 0, 32'h0, 4'h0, 32'h0, 0, 0));
        tbl.push_back(mk(1, 32'h80000000, 32'h11111111, 2, 0, 0, 0, 0, 1, 0, 32'h0, 4'h0, 32'h0, 0, 0));
        tbl.push_back(mk(1, 32'h80000004, 32'h22222222, 2, 0, 0, 0, 1, 1, 1, 32'h80000000, 4'hF, 32'h11111111, 0, 0));
        tbl.push_back(mk(1, 32'h80000008, 32'h33333333, 2, 0, 0, 0, 2, 1, 1, 32'h80000000, 4'hF, 32'h11111111, 0, 0));
        tbl.push_back(mk(1, 32'h8000000C, 32'h44444444, 2, 0, 0, 0, 3, 1, 1, 32'h80000000, 4'hF, 32'h11111111, 0, 0));
        tbl.push_back(mk(1, 32'h80000010, 32'h55555555, 2, 0, 0, 0, 4, 0, 1, 32'h80000000, 4'hF, 32'h11111111, 0, 0));
        tbl.push_back(mk(0, 32'h0, 32'h0, 0, 1, 0, 0, 4, 0, 1, 32'h80000000, 4'hF, 32'h11111111, 0, 0));
        tbl.push_back(mk(0, 32'h0, 32'h0, 0, 1, 0, 0, 3, 1, 1, 32'h80000004, 4'hF, 32'h22222222, 0, 0));
        tbl.push_back(mk(0, 32'h0, 32'h0, 0, 1, 0, 0, 2, 1, 1, 32'h80000008, 4'hF, 32'h33333333, 0, 0));
        tbl.push_back(mk(0, 32'h0, 32'h0, 0, 1, 0, 0, 1, 1, 1, 32'h8000000C, 4'hF, 32'h44444444, 0, 0));
        tbl.push_back(mk(1, 32'h80000001, 32'h0000BEEF, 1, 0, 0, 0, 0, 1, 0, 32'h0, 4'h0, 32'h0, 0, 0));
        tbl.push_back(mk(1, 32'h80000000, 32'h12345678, 3, 0, 0, 0, 0, 1, 0, 32'h0, 4'h0, 32'h0, 1, 0));
        tbl.push_back(mk(0, 32'h0, 32'h0, 0, 0, 0, 0, 0, 1, 0, 32'h0, 4'h0, 32'h0, 1, 0));
        tbl.push_back(mk(0, 32'h0, 32'h0, 0, 0, 0, 0, 0, 1, 0, 32'h0, 4'h0, 32'h0, 0, 0));
        tbl.push_back(mk(1, 32'h80000010, 32'hDEADBEEF, 2, 0, 0, 0, 0, 1, 0, 32'h0, 4'h0, 32'h0, 0, 0));
        tbl.push_back(mk(0, 32'h0, 32'h0, 0, 0, 1, 32'h80000012, 1, 1, 1, 32'h80000010, 4'hF, 32'hDEADBEEF, 0, 1));
        tbl.push_back(mk(0, 32'h0, 32'h0, 0, 0, 1, 32'h80000014, 1, 1, 1, 32'h80000010, 4'hF, 32'hDEADBEEF, 0, 0));
        tbl.push_back(mk(0, 32'h0, 32'h0, 0, 1, 1, 32'h80000012, 1, 1, 1, 32'h80000010, 4'hF, 32'hDEADBEEF, 0, 1));
        tbl.push_back(mk(0, 32'h0, 32'h0, 0, 1, 1, 32'h80000012, 0, 1, 0, 32'h0, 4'h0, 32'h0, 0, 0));

        do_reset();
        foreach (tbl[i]) begin
            v = tbl[i];
            apply(v.sv, v.addr, v.data, v.size, 1'b0, v.wr, v.lc, v.la);
            chk($sformatf("t%0d_count", i), 32'(count), 32'(v.e_cnt));
            chk($sformatf("t%0d_ready", i), 32'(st_ready), 32'(v.e_rdy));
            chk($sformatf("t%0d_wvalid", i), 32'(mem_wvalid), 32'(v.e_wv));
            chk($sformatf("t%0d_err", i), 32'(st_err), 32'(v.e_err));
            chk($sformatf("t%0d_hazard", i), 32'(ld_hazard), 32'(v.e_haz));
            if (v.e_wv) begin
                chk($sformatf("t%0d_waddr", i), mem_waddr, v.e_waddr);
                chk($sformatf("t%0d_wstrb", i), 32'(mem_wstrb), 32'(v.e_wstrb));
                chk($sformatf("t%0d_wdata", i), mem_wdata & lane_mask(v.e_wstrb), v.e_wdata & lane_mask(v.e_wstrb));
            end
            step();
        end

        // Steady enqueue+dequeue at count 2; pointers wrap twice.
        apply(1'b1, 32'h80000100, 32'hA0A0A0A0, 2'd2, 1'b0, 1'b0, 1'b0, 32'h0); step();
        apply(1'b1, 32'h80000104, 32'hA1A1A1A1, 2'd2, 1'b0, 1'b0, 1'b0, 32'h0); step();
        for (int k = 0; k < 6; k++) begin
            apply(1'b1, 32'h80000108 + 32'(4 * k), 32'hB0000000 + 32'(k), 2'd2, 1'b0, 1'b1, 1'b0, 32'h0);
            chk("simul_count", 32'(count), 32'd2);
            step();
        end
        repeat (3) idle(1'b1);
        chk("simul_drained", 32'(empty), 32'd1);

        // Flush holds off stores while the buffer drains.
        apply(1'b1, 32'h80000200, 32'h1, 2'd2, 1'b0, 1'b0, 1'b0, 32'h0); step();
        apply(1'b1, 32'h80000204, 32'h2, 2'd2, 1'b0, 1'b0, 1'b0, 32'h0); step();
        for (int k = 0; k < 5; k++) begin
            apply(1'b1, 32'h80000300, 32'h3, 2'd2, 1'b1, (k >= 2), 1'b0, 32'h0);
            chk("flush_ready", 32'(st_ready), 32'd0);
            step();
        end
        chk("flush_empty", 32'(empty), 32'd1);
        apply(1'b0, 32'h0, 32'h0, 2'd0, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("flush_release", 32'(st_ready), 32'd1);
        step();

        // Asynchronous reset while three stores are queued and draining.
        for (int k = 0; k < 3; k++) begin
            apply(1'b1, 32'h80000400 + 32'(4 * k), 32'hC0C0C0C0, 2'd2, 1'b0, 1'b0, 1'b0, 32'h0);
            step();
        end
        apply(1'b0, 32'h0, 32'h0, 2'd0, 1'b0, 1'b1, 1'b0, 32'h0);
        #3;
        rst = 1'b0;
        #1;
        chk("arst_wvalid", 32'(mem_wvalid), 32'd0);
        chk("arst_count", 32'(count), 32'd0);
        chk("arst_empty", 32'(empty), 32'd1);
        model_q.delete();
        err_exp = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Random traffic against the model.
        for (int k = 0; k < 600; k++) begin
            ra  = 32'h80000000 + 32'($urandom_range(0, 31));
            rla = 32'h80000000 + 32'($urandom_range(0, 31));
            apply(1'($urandom_range(0, 1)), ra, $urandom, 2'($urandom_range(0, 3)),
                  ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), rla);
            step();
        end
        repeat (DEPTH + 1) idle(1'b1);
        chk("final_empty", 32'(empty), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
